jk_latch_sequencer: RTL

Controller that shares one JK_latch instance between two requesters. It accepts JK commands over a valid/ready handshake, arbitrating round-robin between the two requesters. Each command is applied to the latch with a fixed setup → enable-pulse → hold sequence, so j/k are never changed while e=1. After the sequence it samples q/q_bar, checks the result against the expected value and returns a one-cycle response.

---
 rtl/jk_latch_sequencer_pkg.sv | 38 +++
 rtl/rr_arbiter_2.sv | 40 ++++
 rtl/jk_latch_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/jk_latch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_latch_sequencer_pkg
// Description : Shared command encodings, FSM state type and the expected-q
//               rule used by the JK latch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_latch_sequencer_pkg;

    // JK command encodings, {j,k}
    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ENABLE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    // Value q should hold after a command, given q before the pulse
    function automatic logic expected_q(input logic [1:0] cmd, input logic q_prev);
        logic v;
        case (cmd)
            CMD_RESET:  v = 1'b0;
            CMD_SET:    v = 1'b1;
            CMD_TOGGLE: v = ~q_prev;
            default:    v = q_prev;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin arbiter. Grant is combinational; the
//               priority pointer advances only when a grant is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // Requester that wins a tie; requester 0 first after reset
    logic r_ptr;

    // Combinational grant: a lone requester wins, a tie goes to r_ptr
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Hand priority to the other requester after each consumed grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            r_ptr <= ~grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/jk_latch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jk_latch_sequencer
// Description : Shares one JK latch between two requesters. Each accepted
//               command runs setup -> enable pulse -> hold -> capture so j/k
//               never move while e=1, then returns a one-cycle response with
//               the captured q and an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_latch_sequencer
    import jk_latch_sequencer_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [1:0] req0_cmd,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_cmd,
    output logic       req1_ready,
    output logic       j,
    output logic       k,
    output logic       e,
    input  logic       q,
    input  logic       q_bar,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic       rsp_q,
    output logic       rsp_err
);

    localparam logic [CNT_W-1:0] c_setup = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] c_pulse = CNT_W'(PULSE_CYC);
    localparam logic [CNT_W-1:0] c_hold  = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_cmd;
    logic             r_id;
    logic             r_qprev;

    logic             w_idle;
    logic [1:0]       w_grant;
    logic             w_accept;
    logic [1:0]       w_cmd;

    assign w_idle     = (r_state == ST_IDLE);
    assign req0_ready = w_idle & w_grant[0];
    assign req1_ready = w_idle & w_grant[1];
    assign w_accept   = req0_ready | req1_ready;
    assign w_cmd      = w_grant[1] ? req1_cmd : req0_cmd;

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .update (w_accept),
        .grant  (w_grant)
    );

    // Command sequencer: phase counter reloads per phase and counts down to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cmd     <= CMD_HOLD;
            r_id      <= 1'b0;
            r_qprev   <= 1'b0;
            j         <= 1'b0;
            k         <= 1'b0;
            e         <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_q     <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd   <= w_cmd;
                        r_id    <= w_grant[1];
                        {j, k}  <= w_cmd;
                        e       <= 1'b0;
                        r_cnt   <= c_setup;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // q before the pulse is the reference for HOLD/TOGGLE
                    if (r_cnt == c_setup) begin
                        r_qprev <= q;
                    end
                    if (r_cnt == c_one) begin
                        e       <= 1'b1;
                        // a single-cycle pulse keeps a toggle from racing
                        r_cnt   <= (r_cmd == CMD_TOGGLE) ? c_one : c_pulse;
                        r_state <= ST_ENABLE;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                ST_ENABLE: begin
                    if (r_cnt == c_one) begin
                        e       <= 1'b0;
                        r_cnt   <= c_hold;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == c_one) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                ST_CAPTURE: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= r_id;
                    rsp_q     <= q;
                    rsp_err   <= (q == q_bar) | (q != expected_q(r_cmd, r_qprev));
                    j         <= 1'b0;
                    k         <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    e       <= 1'b0;
                    j       <= 1'b0;
                    k       <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
